dmem_arbiter: RTL and testbench

- Two-port arbiter/sequencer that shares the single-port data RAM between instruction fetch (port 0) and load/store unit (port 1).
- Grants one requester at a time and drives the RAM control bus for exactly one cycle per access.
- Captures the RAM's 1-cycle registered read data, sign-extends it, and rejects misaligned, out-of-range or illegal-size accesses with an error response.
- Sits between the core's memory stage and the data RAM.

---
 rtl/dmem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between instruction fetch (port 0) and the LSU (port 1).
// Define DMEM_ARB_RR_EN for round-robin arbitration; by default port 1 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 130001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [2:0]        p0_size,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [2:0]        p1_size,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,
    output logic              ram_MemRead,
    output logic              ram_MemWrite,
    output logic [2:0]        ram_MemSize,
    output logic [31:0]       ram_A,
    output logic [31:0]       ram_WriteData,
    input  logic [31:0]       ram_ReadData
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [ADDR_W-1:0] MEM_WORDS_L = ADDR_W'(MEM_WORDS);

    state_t            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        rerr_q, rerr_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [2:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic              sel_port;
    logic              sel_we;
    logic              sel_err;
    logic [2:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [31:0]       addr32;

`ifdef DMEM_ARB_RR_EN
    logic last_q, last_d;

    // last_q holds the most recently granted port; reset value 1 lets port 0 win first.
    always_comb begin
        sel_port = p1_req;
        if (p0_req && p1_req) sel_port = ~last_q;
        last_d = last_q;
        if (state_q == IDLE && (p0_req || p1_req)) last_d = sel_port;
    end

    always_ff @(posedge clk) begin
        if (reset) last_q <= 1'b1;
        else       last_q <= last_d;
    end
`else
    assign sel_port = p1_req;
`endif

    assign sel_we    = sel_port ? p1_we    : p0_we;
    assign sel_size  = sel_port ? p1_size  : p0_size;
    assign sel_addr  = sel_port ? p1_addr  : p0_addr;
    assign sel_wdata = sel_port ? p1_wdata : p0_wdata;

    always_comb begin
        case (sel_size)
            3'b000, 3'b100: sel_err = 1'b0;
            3'b001, 3'b101: sel_err = sel_addr[0];
            3'b010:         sel_err = |sel_addr[1:0];
            default:        sel_err = 1'b1;
        endcase
        if ((sel_addr >> 2) >= MEM_WORDS_L) sel_err = 1'b1;
    end

    // The RAM returns LSB-aligned, zero-extended data; signed sizes are fixed up here.
    function automatic logic [31:0] extend(input logic [2:0] size, input logic [31:0] d);
        case (size)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'b0, d[7:0]};
            3'b101:  return {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        gnt_d       = 2'b00;
        rvalid_d    = 2'b00;
        rerr_d      = 2'b00;
        rdata_d     = '0;
        port_d      = port_q;
        we_d        = we_q;
        err_d       = err_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    gnt_d       = sel_port ? 2'b10 : 2'b01;
                    port_d      = sel_port;
                    we_d        = sel_we;
                    size_d      = sel_size;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    err_d       = sel_err;
                    mem_read_d  = !sel_err && !sel_we;
                    mem_write_d = !sel_err && sel_we;
                    state_d     = ACCESS;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                rvalid_d = port_q ? 2'b10 : 2'b01;
                rerr_d   = err_q ? rvalid_d : 2'b00;
                if (!we_q && !err_q) rdata_d = extend(size_q, ram_ReadData);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= 2'b00;
            rvalid_q    <= 2'b00;
            rerr_q      <= 2'b00;
            rdata_q     <= '0;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rerr_q      <= rerr_d;
            rdata_q     <= rdata_d;
            port_q      <= port_d;
            we_q        <= we_d;
            err_q       <= err_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign p0_gnt    = gnt_q[0];
    assign p1_gnt    = gnt_q[1];
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];
    assign p0_err    = rerr_q[0];
    assign p1_err    = rerr_q[1];
    assign p0_rdata  = rvalid_q[0] ? rdata_q : '0;
    assign p1_rdata  = rvalid_q[1] ? rdata_q : '0;

    // Halfword lane is picked by RAM address bit 0, so addr[1] moves down there.
    assign addr32        = 32'(addr_q);
    assign ram_A         = (size_q[1:0] == 2'b01) ? {addr32[31:2], 1'b0, addr32[1]} : addr32;
    assign ram_MemRead   = mem_read_q;
    assign ram_MemWrite  = mem_write_q;
    assign ram_MemSize   = {1'b0, size_q[1:0]};
    assign ram_WriteData = wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural 1-cycle-latency RAM.
// Expectations for round-robin follow DMEM_ARB_RR_EN when the bench is built with it.
module tb_dmem_arbiter;
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [2:0]  p0_size = '0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [2:0]  p1_size = '0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        ram_MemRead, ram_MemWrite;
    logic [2:0]  ram_MemSize;
    logic [31:0] ram_A, ram_WriteData;
    logic [31:0] ram_ReadData = '0;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_rd = 0, n_wr = 0, n_both = 0;
    logic [31:0] last_a = '0;
    logic [31:0] mem [0:1023];

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .ram_MemRead(ram_MemRead), .ram_MemWrite(ram_MemWrite), .ram_MemSize(ram_MemSize),
        .ram_A(ram_A), .ram_WriteData(ram_WriteData), .ram_ReadData(ram_ReadData)
    );

    always #5 clk = ~clk;

    // RAM model: halfword lane by A[0], byte lane by A[1:0], zero-extended registered read.
    always @(posedge clk) begin
        if (ram_MemWrite) begin
            case (ram_MemSize[1:0])
                2'b00:   mem[ram_A[11:2]][{ram_A[1:0], 3'b000} +: 8]  <= ram_WriteData[7:0];
                2'b01:   mem[ram_A[11:2]][{ram_A[0], 4'b0000} +: 16] <= ram_WriteData[15:0];
                default: mem[ram_A[11:2]] <= ram_WriteData;
            endcase
        end
        if (ram_MemRead) begin
            case (ram_MemSize[1:0])
                2'b00:   ram_ReadData <= {24'b0, mem[ram_A[11:2]][{ram_A[1:0], 3'b000} +: 8]};
                2'b01:   ram_ReadData <= {16'b0, mem[ram_A[11:2]][{ram_A[0], 4'b0000} +: 16]};
                default: ram_ReadData <= mem[ram_A[11:2]];
            endcase
        end
    end

    always @(negedge clk) begin
        if (ram_MemRead) n_rd++;
        if (ram_MemWrite) n_wr++;
        if (ram_MemRead && ram_MemWrite) n_both++;
        if (ram_MemRead || ram_MemWrite) last_a = ram_A;
    end

    function automatic logic gnt_of(input logic port);
        return port ? p1_gnt : p0_gnt;
    endfunction

    function automatic logic outs_zero();
        return {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, ram_MemRead, ram_MemWrite,
                ram_MemSize, ram_A, ram_WriteData, p0_rdata, p1_rdata} === '0;
    endfunction

    task automatic drive_port(input logic port, input logic req, input logic we, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    // One complete access: request, expect gnt after 1 cycle and rvalid 2 cycles after gnt.
    task automatic do_access(input logic port, input logic we, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input logic exp_err,
                             input logic [31:0] exp_a, input string name);
        exp_t e;
        int t, rd0, wr0, exp_rd, exp_wr;
        logic [31:0] got;
        logic got_err;
        sb.push_back('{port, exp_err, exp_rdata});
        rd0 = n_rd;
        wr0 = n_wr;
        drive_port(port, 1'b1, we, size, addr, wdata);
        t = 0;
        do begin @(negedge clk); t++; end while (!gnt_of(port) && t < 8);
        n_checks++;
        if (gnt_of(port) === 1'b1 && t == 1) n_pass++;
        else $display("FAIL %s grant: gnt=%0b after %0d cycles, required 1 after 1", name, gnt_of(port), t);
        drive_port(port, 1'b0, 1'b0, 3'b000, '0, '0);
        t = 0;
        do begin @(negedge clk); t++; end while (!(p0_rvalid || p1_rvalid) && t < 8);
        e = sb.pop_front();
        n_checks++;
        if ({p1_rvalid, p0_rvalid} === (e.port ? 2'b10 : 2'b01) && t == 2) n_pass++;
        else $display("FAIL %s rvalid: {p1,p0}=%b after %0d cycles, required port %0d after 2",
                      name, {p1_rvalid, p0_rvalid}, t, e.port);
        got     = e.port ? p1_rdata : p0_rdata;
        got_err = e.port ? p1_err : p0_err;
        n_checks++;
        if (got_err === e.err) n_pass++;
        else $display("FAIL %s err: got %b, required %b", name, got_err, e.err);
        n_checks++;
        if (got === e.rdata) n_pass++;
        else $display("FAIL %s rdata: got %h, required %h", name, got, e.rdata);
        exp_rd = (!we && !exp_err) ? 1 : 0;
        exp_wr = (we && !exp_err) ? 1 : 0;
        n_checks++;
        if ((n_rd - rd0) == exp_rd && (n_wr - wr0) == exp_wr) n_pass++;
        else $display("FAIL %s strobes: read %0d write %0d cycles, required %0d %0d",
                      name, n_rd - rd0, n_wr - wr0, exp_rd, exp_wr);
        if (!exp_err) begin
            n_checks++;
            if (last_a === exp_a) n_pass++;
            else $display("FAIL %s ram_A: got %h, required %h", name, last_a, exp_a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (outs_zero()) n_pass++;
        else $display("FAIL reset outputs: gnt %b rvalid %b strobes %b ram_A %h, required all 0",
                      {p1_gnt, p0_gnt}, {p1_rvalid, p0_rvalid}, {ram_MemRead, ram_MemWrite}, ram_A);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs_zero()) n_pass++;
        else $display("FAIL idle outputs: gnt %b rvalid %b, required 0", {p1_gnt, p0_gnt}, {p1_rvalid, p0_rvalid});
    endtask

    task automatic test_write_read();
        do_access(1'b1, 1'b1, SZ_W, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 32'h100, "p1_write_w");
        do_access(1'b1, 1'b0, SZ_W, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 32'h100, "p1_read_w");
    endtask

    task automatic test_sign_extension();
        do_access(1'b0, 1'b1, SZ_W,  32'h200, 32'h80FF7F01, 32'h0, 1'b0, 32'h200, "p0_write_w");
        do_access(1'b1, 1'b0, SZ_B,  32'h202, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h202, "read_b");
        do_access(1'b0, 1'b0, SZ_BU, 32'h203, 32'h0, 32'h00000080, 1'b0, 32'h203, "read_bu");
        do_access(1'b1, 1'b0, SZ_H,  32'h202, 32'h0, 32'hFFFF80FF, 1'b0, 32'h201, "read_h");
        do_access(1'b0, 1'b0, SZ_HU, 32'h200, 32'h0, 32'h00007F01, 1'b0, 32'h200, "read_hu");
        do_access(1'b1, 1'b0, SZ_B,  32'h200, 32'h0, 32'h00000001, 1'b0, 32'h200, "read_b_pos");
        do_access(1'b0, 1'b0, SZ_H,  32'h200, 32'h0, 32'h00007F01, 1'b0, 32'h200, "read_h_pos");
        do_access(1'b1, 1'b0, SZ_HU, 32'h202, 32'h0, 32'h000080FF, 1'b0, 32'h201, "read_hu_hi");
    endtask

    task automatic test_subword_write();
        do_access(1'b1, 1'b1, SZ_H,  32'h106, 32'h0000ABCD, 32'h0, 1'b0, 32'h105, "write_h");
        do_access(1'b0, 1'b1, SZ_B,  32'h105, 32'h00000012, 32'h0, 1'b0, 32'h105, "write_b");
        do_access(1'b1, 1'b0, SZ_W,  32'h104, 32'h0, 32'hABCD1200, 1'b0, 32'h104, "read_merged_w");
        do_access(1'b0, 1'b0, SZ_H,  32'h106, 32'h0, 32'hFFFFABCD, 1'b0, 32'h105, "read_h_hi");
        do_access(1'b1, 1'b0, SZ_BU, 32'h105, 32'h0, 32'h00000012, 1'b0, 32'h105, "read_bu_lane1");
    endtask

    task automatic test_errors();
        do_access(1'b1, 1'b0, SZ_W,   32'h102,      32'h0,  32'h0, 1'b1, 32'h0, "err_w_misalign");
        do_access(1'b0, 1'b0, SZ_H,   32'h101,      32'h0,  32'h0, 1'b1, 32'h0, "err_h_misalign");
        do_access(1'b1, 1'b0, 3'b011, 32'h100,      32'h0,  32'h0, 1'b1, 32'h0, "err_size_011");
        do_access(1'b0, 1'b0, 3'b110, 32'h100,      32'h0,  32'h0, 1'b1, 32'h0, "err_size_110");
        do_access(1'b0, 1'b0, SZ_W,   32'h0007F000, 32'h0,  32'h0, 1'b1, 32'h0, "err_range_rd");
        do_access(1'b1, 1'b1, SZ_W,   32'h0007F000, 32'h55, 32'h0, 1'b1, 32'h0, "err_range_wr");
        do_access(1'b0, 1'b0, SZ_W,   32'h0007EF44, 32'h0,  32'h0, 1'b1, 32'h0, "err_first_bad_word");
        do_access(1'b1, 1'b0, SZ_W,   32'h0007EF40, 32'h0,  32'h0, 1'b0, 32'h0007EF40, "last_good_word");
    endtask

    task automatic test_arbitration();
        exp_t e;
        int g, prev;
        logic exp_port;
        do_access(1'b0, 1'b0, SZ_W, 32'h200, 32'h0, 32'h80FF7F01, 1'b0, 32'h200, "arb_pre_p0");
        drive_port(1'b0, 1'b1, 1'b0, SZ_W, 32'h200, 32'h0);
        drive_port(1'b1, 1'b1, 1'b0, SZ_W, 32'h100, 32'h0);
        g = 0;
        prev = -2;
        for (int c = 1; c <= 40 && (g < 4 || sb.size() != 0); c++) begin
            @(negedge clk);
            if (p0_gnt || p1_gnt) begin
`ifdef DMEM_ARB_RR_EN
                exp_port = (g % 2 == 0);
`else
                exp_port = 1'b1;
`endif
                n_checks++;
                if ({p1_gnt, p0_gnt} === (exp_port ? 2'b10 : 2'b01) && c - prev == 3) n_pass++;
                else $display("FAIL arb grant %0d: {p1,p0}=%b spacing %0d, required port %0d spacing 3",
                              g, {p1_gnt, p0_gnt}, c - prev, exp_port);
                prev = c;
                sb.push_back('{exp_port, 1'b0, exp_port ? 32'hDEADBEEF : 32'h80FF7F01});
                g++;
                if (g == 4) begin
                    drive_port(1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
                    drive_port(1'b1, 1'b0, 1'b0, 3'b000, '0, '0);
                end
            end
            if (p0_rvalid || p1_rvalid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL arb unexpected rvalid: {p1,p0}=%b, required none", {p1_rvalid, p0_rvalid});
                end else begin
                    e = sb.pop_front();
                    n_checks++;
                    if ({p1_rvalid, p0_rvalid} === (e.port ? 2'b10 : 2'b01) &&
                        (e.port ? p1_rdata : p0_rdata) === e.rdata) n_pass++;
                    else $display("FAIL arb response: {p1,p0}=%b rdata %h, required port %0d rdata %h",
                                  {p1_rvalid, p0_rvalid}, e.port ? p1_rdata : p0_rdata, e.port, e.rdata);
                end
            end
        end
        n_checks++;
        if (g == 4 && sb.size() == 0) n_pass++;
        else $display("FAIL arb completion: %0d grants, %0d pending, required 4 grants 0 pending", g, sb.size());
    endtask

    task automatic test_reset_mid_access();
        logic seen;
        drive_port(1'b0, 1'b1, 1'b0, SZ_W, 32'h100, 32'h0);
        @(negedge clk);
        n_checks++;
        if (p0_gnt === 1'b1 && ram_MemRead === 1'b1) n_pass++;
        else $display("FAIL midreset access: gnt %b read %b, required 1 1", p0_gnt, ram_MemRead);
        reset = 1'b1;
        drive_port(1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
        @(negedge clk);
        n_checks++;
        if (outs_zero()) n_pass++;
        else $display("FAIL midreset outputs: gnt %b rvalid %b strobes %b ram_A %h, required all 0",
                      {p1_gnt, p0_gnt}, {p1_rvalid, p0_rvalid}, {ram_MemRead, ram_MemWrite}, ram_A);
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (p0_rvalid || p1_rvalid) seen = 1'b1;
        end
        n_checks++;
        if (!seen) n_pass++;
        else $display("FAIL midreset rvalid: got 1 after abandoned access, required 0");
        do_access(1'b0, 1'b0, SZ_W, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 32'h100, "after_reset_p0");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int g1, g2, extra, nresp;
        g1 = -1; g2 = -1; extra = 0; nresp = 0;
        sb.push_back('{1'b0, 1'b0, 32'h80FF7F01});
        sb.push_back('{1'b0, 1'b0, 32'h80FF7F01});
        drive_port(1'b0, 1'b1, 1'b0, SZ_W, 32'h200, 32'h0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (p0_gnt || p1_gnt) begin
                if (g1 < 0) g1 = c;
                else if (g2 < 0) begin
                    g2 = c;
                    drive_port(1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
                end else extra++;
            end
            if (p0_rvalid && sb.size() != 0) begin
                e = sb.pop_front();
                nresp++;
                n_checks++;
                if (p0_rdata === e.rdata && p0_err === e.err && c == (nresp == 1 ? g1 : g2) + 2) n_pass++;
                else $display("FAIL b2b response %0d: rdata %h err %b at cycle %0d, required %h 0 two after grant",
                              nresp, p0_rdata, p0_err, c, e.rdata);
            end
        end
        n_checks++;
        if (g1 == 1 && g2 == 4 && extra == 0) n_pass++;
        else $display("FAIL b2b grants: at %0d and %0d extra %0d, required 1 and 4 extra 0", g1, g2, extra);
        n_checks++;
        if (nresp == 2 && sb.size() == 0) n_pass++;
        else $display("FAIL b2b responses: %0d seen, required 2", nresp);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_write_read();
        test_sign_extension();
        test_subword_write();
        test_errors();
        test_arbitration();
        test_reset_mid_access();
        test_back_to_back();
        n_checks++;
        if (n_both == 0) n_pass++;
        else $display("FAIL strobe exclusivity: both strobes high in %0d cycles, required 0", n_both);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end
endmodule
